// File: rtl/ex_mem_skid_reg.sv
// Execute-to-Memory pipeline boundary register.
// A two-entry skid buffer (MAIN + SKID) under a valid/ready handshake. MAIN
// always drives the Memory-stage outputs. SKID catches the one extra entry
// Execute can push in the cycle backpressure appears. in_ready is derived only
// from a flop, so Memory-stage backpressure never reaches Execute
// combinationally.
module ex_mem_skid_reg #(
    parameter int WIDTH      = 16,
    parameter int REG_ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_result,
    input  logic [WIDTH-1:0]      in_store,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  in_we,
    input  logic                  in_mem_rd,
    input  logic                  in_mem_wr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_result,
    output logic [WIDTH-1:0]      out_store,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic                  out_we,
    output logic                  out_mem_rd,
    output logic                  out_mem_wr
);

    // Packed payload: {result, store, rd, we, mem_rd, mem_wr}
    localparam int PW = 2 * WIDTH + REG_ADDR_W + 3;

    // State encoding is {main_v, skid_v}; 2'b01 is illegal
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        FULL  = 2'b11
    } state_t;

    state_t        state_r;
    logic [PW-1:0] main_r;
    logic [PW-1:0] skid_r;
    logic [PW-1:0] in_payload_s;
    logic          push_s;
    logic          pop_s;

    assign in_payload_s = {in_result, in_store, in_rd, in_we, in_mem_rd, in_mem_wr};

    // Handshakes: in_ready and out_valid both come straight from state flops
    assign in_ready  = ~state_r[0];
    assign out_valid = state_r[1];
    assign push_s    = in_valid & ~state_r[0];
    assign pop_s     = state_r[1] & out_ready;

    // Outputs are taken directly from the MAIN register
    assign {out_result, out_store, out_rd, out_we, out_mem_rd, out_mem_wr} = main_r;

    // Occupancy FSM plus MAIN/SKID payload capture; flush only clears validity
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= EMPTY;
            main_r  <= {PW{1'b0}};
            skid_r  <= {PW{1'b0}};
        end else if (flush) begin
            state_r <= EMPTY;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (push_s) begin
                        main_r  <= in_payload_s;
                        state_r <= ONE;
                    end else begin
                        state_r <= EMPTY;
                    end
                end
                ONE: begin
                    if (push_s && !pop_s) begin
                        skid_r  <= in_payload_s;
                        state_r <= FULL;
                    end else if (push_s && pop_s) begin
                        main_r  <= in_payload_s;
                        state_r <= ONE;
                    end else if (pop_s) begin
                        state_r <= EMPTY;
                    end else begin
                        state_r <= ONE;
                    end
                end
                FULL: begin
                    if (pop_s) begin
                        main_r  <= skid_r;
                        state_r <= ONE;
                    end else begin
                        state_r <= FULL;
                    end
                end
                default: begin
                    // Illegal encoding: discard contents rather than guess
                    state_r <= EMPTY;
                end
            endcase
        end
    end

endmodule
